// File: rtl/nm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nm_pkg
//  Purpose  : Shared constants and types for the neuron-array top level:
//             host register codes, NSR bit positions, sequencer states and
//             the register map of the neuron-cluster model.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
package nm_pkg;

  // Host-visible register codes handled by the top level
  localparam logic [3:0] NETWORK_STATUS = 4'hD;
  localparam logic [3:0] FORGET         = 4'hF;

  // Network Status Register bit positions
  localparam int NSR_UNC = 2;
  localparam int NSR_ID  = 3;
  localparam int NSR_SR  = 4;
  localparam int NSR_KNN = 5;

  // Cluster register map (decoded inside each cluster)
  localparam logic [3:0] CL_DELAY = 4'h1;  // write: {cluster idx[top nibble], ready delay[4:0]}
  localparam logic [3:0] CL_IDENT = 4'h2;  // read : each cluster clears its own index bit
  localparam logic [3:0] CL_LINES = 4'h3;  // write: [0] id claim, [1] learned (clears unclearn)
  localparam logic [3:0] CL_MODE  = 4'h4;  // read : [0] SR, [1] KNN as seen by the cluster

  // Host access sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/nm_array_if.sv
`default_nettype none
// ============================================================================
//  Module   : nm_array_if
//  Purpose  : Host bus of the neuron array (chip select, data strobe,
//             register address, write/read data and ready).
//  Revision : 1.0 - initial parametrised release
// ============================================================================
interface nm_array_if #(
  parameter int DATA_W = 16
);
  logic              CS_l;
  logic              DS;
  logic              RW_l;
  logic [3:0]        REG;
  logic [DATA_W-1:0] DATA_IN;
  logic [DATA_W-1:0] DATA_OUT;
  logic              DATA_OE;
  logic              RDY;

  modport master (
    output CS_l, DS, RW_l, REG, DATA_IN,
    input  DATA_OUT, DATA_OE, RDY
  );

  modport slave (
    input  CS_l, DS, RW_l, REG, DATA_IN,
    output DATA_OUT, DATA_OE, RDY
  );
endinterface
`default_nettype wire

// File: rtl/nm_array_cluster.sv
`default_nettype none
// ============================================================================
//  Module   : nm_array_cluster
//  Purpose  : Behavioural neuron-cluster model: programmable ready delay,
//             identity read-back, ID/UNC line drivers and a registered
//             daisy-chain stage.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module nm_array_cluster
  import nm_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IDX    = 0
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              reset_l,
  input  wire logic              ds,
  input  wire logic [3:0]        reg_sel,
  input  wire logic              read,
  input  wire logic [DATA_W-1:0] data_in,
  input  wire logic              sr,
  input  wire logic              knn,
  input  wire logic              oktolearn_in,
  input  wire logic              dci,
  output logic                   ready,
  output logic [DATA_W-1:0]      data_out,
  output logic                   id,
  output logic                   unclearn,
  output logic                   dco
);
  localparam logic [3:0] C_IDX = 4'(IDX);

  logic [4:0] delay_q, delay_d;
  logic [4:0] cnt_q, cnt_d;
  logic       id_q, id_d;
  logic       unc_q, unc_d;
  logic       dco_q, dco_d;
  logic       unused_data;

  assign unused_data = &{1'b0, data_in};

  // Next-state: busy countdown per access, register writes, sync clear
  always_comb begin
    delay_d = delay_q;
    id_d    = id_q;
    unc_d   = unc_q;
    dco_d   = dci;
    cnt_d   = (cnt_q != 5'd0) ? cnt_q - 5'd1 : cnt_q;
    if (ds) begin
      cnt_d = delay_q;
      if (!read) begin
        if (reg_sel == CL_DELAY && data_in[DATA_W-1 -: 4] == C_IDX) delay_d = data_in[4:0];
        if (reg_sel == CL_LINES) begin
          id_d  = data_in[0] & oktolearn_in;
          unc_d = ~data_in[1];
        end
      end
    end
    if (!reset_l) begin
      delay_d = 5'd0;
      cnt_d   = 5'd0;
      id_d    = 1'b0;
      unc_d   = 1'b1;
      dco_d   = 1'b0;
    end
  end

  // Cluster state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_q <= 5'd0;
      cnt_q   <= 5'd0;
      id_q    <= 1'b0;
      unc_q   <= 1'b1;
      dco_q   <= 1'b0;
    end else begin
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      unc_q   <= unc_d;
      dco_q   <= dco_d;
    end
  end

  // Read mux; unaddressed registers return all-ones so the top can AND
  always_comb begin
    data_out = '1;
    if (reg_sel == CL_IDENT) begin
      data_out[IDX % DATA_W] = 1'b0;
    end else if (reg_sel == CL_MODE) begin
      data_out[0] = sr;
      data_out[1] = knn;
    end
  end

  assign ready    = (cnt_q == 5'd0);
  assign id       = id_q;
  assign unclearn = unc_q;
  assign dco      = dco_q;
endmodule
`default_nettype wire

// File: rtl/nm_clk_gate.sv
`default_nettype none
// ============================================================================
//  Module   : nm_clk_gate
//  Purpose  : Glitch-free clock gate; the enable is captured by a latch that
//             is transparent only while the clock is low.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module nm_clk_gate (
  input  wire logic clk,
  input  wire logic en,
  output logic      gclk
);
  logic en_lat;

  // Enable may only change while clk is low, so gclk never gets a runt pulse
  always_latch begin
    if (!clk) en_lat <= en;
  end

  assign gclk = clk & en_lat;
endmodule
`default_nettype wire

// File: rtl/nm_array_top.sv
`default_nettype none
// ============================================================================
//  Module   : nm_array_top
//  Purpose  : Neuron-array top: reset stretcher, standby clock gate, NSR,
//             registered host access sequencer and cluster aggregation.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module nm_array_top
  import nm_pkg::*;
#(
  parameter int NUM_CLUSTERS = 3,
  parameter int DATA_W       = 16,
  parameter int RESET_CYCLES = 256
) (
  input  wire logic  G_CLK,
  input  wire logic  G_RESET_l,
  nm_array_if.slave  host,
  input  wire logic  ID_l_IN,
  input  wire logic  UNC_l_IN,
  output logic       ID_l_OE,
  output logic       UNC_l_OE,
  input  wire logic  DCI,
  output logic       DCO
);
  localparam int CNT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  // Reset stretcher
  logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
  logic             reset_done;

  // DS synchroniser, standby and NSR
  logic ds_s1_q, ds_s1_d, ds_s2_q, ds_s2_d, ds_prev_q, ds_prev_d;
  logic ds_rise;
  logic standby_q, standby_d;
  logic [DATA_W-1:0] nsr_q, nsr_d;

  // Sequencer
  seq_state_e        state_q;
  logic              rdy_q, data_oe_q, clu_ds_q, forget_q;
  logic [DATA_W-1:0] data_out_q, cap_data_q;
  logic [3:0]        cap_reg_q;
  logic              cap_read_q;

  // Cluster side
  logic                    cluster_clk, clu_reset_l, all_ready;
  logic [NUM_CLUSTERS-1:0] ready_v, id_v, unc_v;
  logic [NUM_CLUSTERS:0]   dc_v;
  logic [DATA_W-1:0]       data_v [NUM_CLUSTERS];
  logic [DATA_W-1:0]       agg_data;

  assign reset_done = (rst_cnt_q == '0);
  assign ds_rise    = ds_s2_q & ~ds_prev_q;

  // Count down to zero once the external reset is released
  always_comb begin
    rst_cnt_d = reset_done ? rst_cnt_q : rst_cnt_q - CNT_W'(1);
  end

  // Stretch counter reloads asynchronously whenever G_RESET_l is low
  always_ff @(posedge G_CLK or negedge G_RESET_l) begin
    if (!G_RESET_l) rst_cnt_q <= CNT_W'(RESET_CYCLES - 1);
    else            rst_cnt_q <= rst_cnt_d;
  end

  // Synchroniser, standby sampling (IDLE only) and NSR update
  always_comb begin
    ds_s1_d   = host.DS;
    ds_s2_d   = ds_s1_q;
    ds_prev_d = ds_s2_q;
    standby_d = (state_q == ST_IDLE) ? host.CS_l : standby_q;
    nsr_d          = nsr_q;
    nsr_d[NSR_ID]  = ~ID_l_IN;
    nsr_d[NSR_UNC] = ~UNC_l_IN;
    if (state_q == ST_ISSUE && !cap_read_q && cap_reg_q == NETWORK_STATUS) nsr_d = cap_data_q;
    if (!reset_done) begin
      ds_s1_d   = 1'b0;
      ds_s2_d   = 1'b0;
      ds_prev_d = 1'b0;
      standby_d = 1'b0;
      nsr_d     = '0;
    end
  end

  // Registers for synchroniser, standby and NSR
  always_ff @(posedge G_CLK or negedge G_RESET_l) begin
    if (!G_RESET_l) begin
      ds_s1_q   <= 1'b0;
      ds_s2_q   <= 1'b0;
      ds_prev_q <= 1'b0;
      standby_q <= 1'b0;
      nsr_q     <= '0;
    end else begin
      ds_s1_q   <= ds_s1_d;
      ds_s2_q   <= ds_s2_d;
      ds_prev_q <= ds_prev_d;
      standby_q <= standby_d;
      nsr_q     <= nsr_d;
    end
  end

  // Host access sequencer: one cluster cycle per DS pulse, registered outputs
  always_ff @(posedge G_CLK or negedge G_RESET_l) begin
    if (!G_RESET_l) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      data_oe_q  <= 1'b0;
      data_out_q <= '0;
      clu_ds_q   <= 1'b0;
      forget_q   <= 1'b0;
      cap_reg_q  <= 4'h0;
      cap_read_q <= 1'b0;
      cap_data_q <= '0;
    end else if (!reset_done) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      data_oe_q  <= 1'b0;
      data_out_q <= '0;
      clu_ds_q   <= 1'b0;
      forget_q   <= 1'b0;
      cap_reg_q  <= 4'h0;
      cap_read_q <= 1'b0;
      cap_data_q <= '0;
    end else begin
      clu_ds_q <= 1'b0;
      forget_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rdy_q <= 1'b1;
          if (ds_rise && !standby_q) begin
            cap_reg_q  <= host.REG;
            cap_read_q <= host.RW_l;
            cap_data_q <= host.DATA_IN;
            rdy_q      <= 1'b0;
            state_q    <= ST_ISSUE;
            // FORGET becomes a one-cycle synchronous cluster clear, not an access
            if (!host.RW_l && host.REG == FORGET) forget_q <= 1'b1;
            else                                  clu_ds_q <= 1'b1;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (all_ready) begin
            if (cap_read_q) data_out_q <= agg_data;
            data_oe_q <= cap_read_q;
            rdy_q     <= 1'b1;
            state_q   <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Level test also releases HOLD when DS already fell during the access
          if (!ds_s2_q) begin
            data_oe_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign clu_reset_l = reset_done & ~forget_q;

  nm_clk_gate u_clk_gate (
    .clk  (G_CLK),
    .en   (~standby_q),
    .gclk (cluster_clk)
  );

  assign dc_v[0] = DCI;

  generate
    for (genvar k = 0; k < NUM_CLUSTERS; k++) begin : g_cluster
      nm_array_cluster #(
        .DATA_W (DATA_W),
        .IDX    (k)
      ) u_cluster (
        .clk          (cluster_clk),
        .rst_n        (G_RESET_l),
        .reset_l      (clu_reset_l),
        .ds           (clu_ds_q),
        .reg_sel      (cap_reg_q),
        .read         (cap_read_q),
        .data_in      (cap_data_q),
        .sr           (nsr_q[NSR_SR]),
        .knn          (nsr_q[NSR_KNN]),
        .oktolearn_in (UNC_l_IN),
        .dci          (dc_v[k]),
        .ready        (ready_v[k]),
        .data_out     (data_v[k]),
        .id           (id_v[k]),
        .unclearn     (unc_v[k]),
        .dco          (dc_v[k+1])
      );
    end
  endgenerate

  // Wired-AND of cluster read data, masked by NSR when it is the target
  always_comb begin
    agg_data = (cap_reg_q == NETWORK_STATUS) ? nsr_q : '1;
    for (int k = 0; k < NUM_CLUSTERS; k++) agg_data = agg_data & data_v[k];
  end

  assign all_ready     = &ready_v;
  assign ID_l_OE       = (|id_v) & UNC_l_IN;
  assign UNC_l_OE      = ~(&unc_v);
  assign DCO           = dc_v[NUM_CLUSTERS];
  assign host.RDY      = rdy_q;
  assign host.DATA_OUT = data_out_q;
  assign host.DATA_OE  = data_oe_q;
endmodule
`default_nettype wire

// File: tb/tb_nm_array_top.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nm_array_top
//  Purpose  : Self-checking bench for nm_array_top with five clusters and a
//             16-cycle reset stretch.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module tb_nm_array_top;
  localparam int NC = 5;
  localparam int DW = 16;
  localparam int RC = 16;

  logic clk = 1'b0;
  logic rst_l, id_l_in, unc_l_in, dci;
  logic id_l_oe, unc_l_oe, dco;

  int checks = 0;
  int errors = 0;
  int ds_cnt = 0;
  int fg_cnt = 0;
  int gclk_cnt = 0;

  nm_array_if #(.DATA_W(DW)) bus ();

  nm_array_top #(
    .NUM_CLUSTERS (NC),
    .DATA_W       (DW),
    .RESET_CYCLES (RC)
  ) dut (
    .G_CLK     (clk),
    .G_RESET_l (rst_l),
    .host      (bus),
    .ID_l_IN   (id_l_in),
    .UNC_l_IN  (unc_l_in),
    .ID_l_OE   (id_l_oe),
    .UNC_l_OE  (unc_l_oe),
    .DCI       (dci),
    .DCO       (dco)
  );

  always #5 clk = ~clk;

  // Count cluster strobes, FORGET clears and gated-clock edges
  always @(posedge clk) begin
    if (dut.clu_ds_q) ds_cnt++;
    if (dut.reset_done && !dut.clu_reset_l) fg_cnt++;
  end
  always @(posedge dut.cluster_clk) gclk_cnt++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_access(input logic rw, input logic [3:0] r, input logic [DW-1:0] d,
                           output logic [DW-1:0] rdata, output logic oe);
    int n;
    bus.RW_l    = rw;
    bus.REG     = r;
    bus.DATA_IN = d;
    bus.DS      = 1'b1;
    tick(4);
    n = 0;
    while (!bus.RDY && n < 200) begin
      tick(1);
      n++;
    end
    chk("access_rdy", {31'd0, bus.RDY}, 32'd1);
    rdata  = bus.DATA_OUT;
    oe     = bus.DATA_OE;
    bus.DS = 1'b0;
    tick(5);
    chk("oe_release", {31'd0, bus.DATA_OE}, 32'd0);
  endtask

  typedef struct {
    logic          rw;
    logic [3:0]    r;
    logic [DW-1:0] d;
    logic          id_l;
    logic          unc_l;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vt[13];

  initial begin
    logic [DW-1:0] rd;
    logic          oe;
    int            ds0, fg0, g0, n;

    vt[0]  = '{1'b1, 4'hD, 16'h0000, 1'b1, 1'b1, 16'h0000};
    vt[1]  = '{1'b0, 4'hD, 16'h0030, 1'b1, 1'b1, 16'h0000};
    vt[2]  = '{1'b1, 4'hD, 16'h0000, 1'b1, 1'b1, 16'h0030};
    vt[3]  = '{1'b1, 4'h4, 16'h0000, 1'b1, 1'b1, 16'hFFFF};
    vt[4]  = '{1'b1, 4'h2, 16'h0000, 1'b1, 1'b1, 16'hFFE0};
    vt[5]  = '{1'b0, 4'hD, 16'hFFD3, 1'b1, 1'b1, 16'h0000};
    vt[6]  = '{1'b1, 4'hD, 16'h0000, 1'b1, 1'b1, 16'hFFD3};
    vt[7]  = '{1'b1, 4'h4, 16'h0000, 1'b1, 1'b1, 16'hFFFD};
    vt[8]  = '{1'b0, 4'hD, 16'h000C, 1'b1, 1'b1, 16'h0000};
    vt[9]  = '{1'b1, 4'hD, 16'h0000, 1'b1, 1'b1, 16'h0000};
    vt[10] = '{1'b1, 4'hD, 16'h0000, 1'b0, 1'b1, 16'h0008};
    vt[11] = '{1'b1, 4'hD, 16'h0000, 1'b1, 1'b0, 16'h0004};
    vt[12] = '{1'b1, 4'h0, 16'h0000, 1'b1, 1'b1, 16'hFFFF};

    rst_l = 1'b0; id_l_in = 1'b1; unc_l_in = 1'b1; dci = 1'b0;
    bus.CS_l = 1'b0; bus.DS = 1'b0; bus.RW_l = 1'b1; bus.REG = 4'h0; bus.DATA_IN = '0;
    tick(3);

    // Reset values and stretched-reset length
    chk("rst_rdy",      {31'd0, bus.RDY},      32'd0);
    chk("rst_oe",       {31'd0, bus.DATA_OE},  32'd0);
    chk("rst_dout",     {16'd0, bus.DATA_OUT}, 32'd0);
    chk("rst_id_oe",    {31'd0, id_l_oe},      32'd0);
    chk("rst_unc_oe",   {31'd0, unc_l_oe},     32'd0);
    rst_l = 1'b1;
    tick(RC - 1);
    chk("stretch_rdy_low",  {31'd0, bus.RDY}, 32'd0);
    tick(1);
    chk("stretch_rdy_high", {31'd0, bus.RDY}, 32'd1);

    // Table-driven register accesses
    for (int i = 0; i < 13; i++) begin
      id_l_in  = vt[i].id_l;
      unc_l_in = vt[i].unc_l;
      do_access(vt[i].rw, vt[i].r, vt[i].d, rd, oe);
      chk($sformatf("vec%0d_oe", i), {31'd0, oe}, {31'd0, vt[i].rw});
      if (vt[i].rw) chk($sformatf("vec%0d_data", i), {16'd0, rd}, {16'd0, vt[i].exp});
    end
    id_l_in = 1'b1; unc_l_in = 1'b1;

    // Daisy chain: one register stage per cluster
    dci = 1'b1;
    tick(NC - 1);
    chk("dco_before", {31'd0, dco}, 32'd0);
    tick(1);
    chk("dco_after",  {31'd0, dco}, 32'd1);
    dci = 1'b0;
    tick(NC + 1);

    // Long DS: single strobe, RDY back high while DS still high
    ds0 = ds_cnt;
    bus.RW_l = 1'b0; bus.REG = 4'h0; bus.DATA_IN = '0; bus.DS = 1'b1;
    tick(10);
    chk("longds_rdy_early", {31'd0, bus.RDY}, 32'd1);
    tick(30);
    chk("longds_rdy_late",  {31'd0, bus.RDY}, 32'd1);
    bus.DS = 1'b0;
    tick(5);
    chk("longds_one_strobe", ds_cnt - ds0, 1);

    // DS falls during ISSUE: access still completes once
    ds0 = ds_cnt;
    bus.DS = 1'b1;
    tick(3);
    bus.DS = 1'b0;
    tick(8);
    chk("shortds_strobe", ds_cnt - ds0, 1);
    chk("shortds_rdy",    {31'd0, bus.RDY}, 32'd1);

    // FORGET clears clusters for one cycle, NSR untouched
    do_access(1'b0, 4'h3, 16'h0003, rd, oe);
    chk("lines_id_oe",  {31'd0, id_l_oe},  32'd1);
    chk("lines_unc_oe", {31'd0, unc_l_oe}, 32'd1);
    do_access(1'b0, 4'hD, 16'h0030, rd, oe);
    ds0 = ds_cnt; fg0 = fg_cnt;
    do_access(1'b0, 4'hF, 16'h0000, rd, oe);
    chk("forget_pulse",    fg_cnt - fg0, 1);
    chk("forget_no_ds",    ds_cnt - ds0, 0);
    chk("forget_id_oe",    {31'd0, id_l_oe},  32'd0);
    chk("forget_unc_oe",   {31'd0, unc_l_oe}, 32'd0);
    do_access(1'b1, 4'hD, 16'h0000, rd, oe);
    chk("forget_nsr", {16'd0, rd}, 32'h0030);

    // Cluster 2 holds ready low for 20 cycles
    do_access(1'b0, 4'h1, 16'h2014, rd, oe);
    bus.RW_l = 1'b1; bus.REG = 4'h2; bus.DS = 1'b1;
    tick(24);
    chk("delay_rdy_low",  {31'd0, bus.RDY}, 32'd0);
    tick(1);
    chk("delay_rdy_high", {31'd0, bus.RDY}, 32'd1);
    chk("delay_data",     {16'd0, bus.DATA_OUT}, 32'h0000FFE0);
    bus.DS = 1'b0;
    tick(5);

    // Standby requested mid-access with a 10-cycle cluster delay
    do_access(1'b0, 4'h1, 16'h200A, rd, oe);
    bus.RW_l = 1'b1; bus.REG = 4'h2; bus.DS = 1'b1;
    tick(6);
    bus.CS_l = 1'b1;
    g0 = gclk_cnt;
    n = 0;
    while (!bus.RDY && n < 40) begin
      tick(1);
      n++;
    end
    chk("stby_access_rdy",  {31'd0, bus.RDY}, 32'd1);
    chk("stby_access_data", {16'd0, bus.DATA_OUT}, 32'h0000FFE0);
    chk("stby_clk_ran",     {31'd0, (gclk_cnt - g0) > 0}, 32'd1);
    bus.DS = 1'b0;
    tick(5);
    g0 = gclk_cnt; ds0 = ds_cnt;
    bus.RW_l = 1'b0; bus.REG = 4'h0; bus.DS = 1'b1;
    tick(3);
    bus.DS = 1'b0;
    tick(7);
    chk("stby_clk_stopped", gclk_cnt - g0, 0);
    chk("stby_ds_ignored",  ds_cnt - ds0, 0);
    chk("stby_rdy",         {31'd0, bus.RDY}, 32'd1);
    bus.CS_l = 1'b0;
    tick(3);
    chk("stby_clk_resumed", {31'd0, (gclk_cnt - g0) > 0}, 32'd1);
    do_access(1'b0, 4'h1, 16'h2000, rd, oe);

    // Reset during HOLD aborts and restarts the stretcher
    bus.RW_l = 1'b1; bus.REG = 4'hD; bus.DS = 1'b1;
    tick(8);
    chk("abort_pre_oe",   {31'd0, bus.DATA_OE}, 32'd1);
    chk("abort_pre_data", {16'd0, bus.DATA_OUT}, 32'h0030);
    rst_l = 1'b0;
    #1;
    chk("abort_oe",   {31'd0, bus.DATA_OE},  32'd0);
    chk("abort_data", {16'd0, bus.DATA_OUT}, 32'd0);
    chk("abort_rdy",  {31'd0, bus.RDY},      32'd0);
    bus.DS = 1'b0;
    tick(2);
    rst_l = 1'b1;
    tick(RC - 1);
    chk("abort_stretch_low",  {31'd0, bus.RDY}, 32'd0);
    tick(1);
    chk("abort_stretch_high", {31'd0, bus.RDY}, 32'd1);
    do_access(1'b1, 4'hD, 16'h0000, rd, oe);
    chk("abort_nsr_cleared", {16'd0, rd}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/nm_array_top.md
# nm_array_top

Parametrised successor to the three-cluster neuron-array top level. It instantiates NUM_CLUSTERS neuron clusters in one daisy chain and stretches the external reset. It gates the cluster clock for standby, owns the Network Status Register (NSR) and aggregates the cluster ready/ID/UNC/data lines. New in this generation: a registered host-bus access sequencer. It turns each DS pulse into exactly one single-cycle cluster access, holds read data until DS falls, and issues FORGET as a clean synchronous pulse instead of a DS-derived combinational reset.

## Interface
- NUM_CLUSTERS, 3: number of neuroncluster instances, ≥1.
- DATA_W, 16: host data and NSR width, ≥6.
- RESET_CYCLES, 256: stretched-reset length in G_CLK cycles, ≥2.
- G_CLK  in  1  sole clock; all logic on rising edge.
- G_RESET_l  in  1  asynchronous, active-low reset.
- CS_l  in  1  chip select; high requests standby.
- DS  in  1  data strobe, asynchronous to G_CLK.
- RW_l  in  1  1 = read, 0 = write.
- REG  in  4  register address.
- DATA_IN  in  DATA_W  host write data.
- DATA_OUT  out  DATA_W  read data. Reset value 0.
- DATA_OE  out  1  read-data drive enable. Reset value 0.
- ID_l_IN / UNC_l_IN  in  1  wired chip-bus ID_l / UNC_l pad inputs.
- ID_l_OE / UNC_l_OE  out  1  pull-low enables for ID_l / UNC_l. Reset value 0.
- DCI  in  1  daisy-chain in, to cluster 0.
- DCO  out  1  daisy-chain out, from cluster NUM_CLUSTERS-1.
- RDY  out  1  host ready. Reset value 0.

## Operation
- Reset stretcher
  - On G_RESET_l low, the counter loads RESET_CYCLES-1 and then decrements each cycle.
  - reset_done = (count==0).
  - All logic other than the counter is held in reset while reset_done=0.
- Standby
  - standby_r samples CS_l each cycle, but only while the sequencer is in IDLE.
  - Cluster clock = G_CLK gated by ~standby_r.
  - While standby_r=1, DS edges are ignored.
- DS sync
  - DS passes through a 2-flop synchronizer plus an edge register.
  - ds_rise = sync & ~prev; ds_fall = ~sync & prev.
- Sequencer states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: RDY=1. On ds_rise with standby_r=0, capture REG, RW_l and DATA_IN, then go to ISSUE.
  - ISSUE (1 cycle): RDY=0.
    - Normal access: cluster ds=1 with the captured reg/read/data.
    - Captured write to REG=0xF (FORGET): cluster ds=0 and cluster reset_l driven 0 for this cycle only.
    - Captured write to REG=0xD: NSR is written.
    - Next state: WAIT.
  - WAIT: RDY=0. When AND(cluster ready)=1:
    - Read: register the aggregated data into DATA_OUT.
    - Go to HOLD.
  - HOLD:
    - RDY=1.
    - DATA_OE = captured read.
    - On ds_fall: DATA_OE←0, go to IDLE.
    - If DS is already low on HOLD entry, the state still lasts 1 cycle.
- Read data
  - Aggregated data = AND over cluster data_out, ANDed with (captured REG==0xD ? NSR : all-ones).
  - Clusters not addressed drive all-ones.
- NSR
  - Each cycle: NSR[3] ← ~ID_l_IN, NSR[2] ← ~UNC_l_IN.
  - A write in ISSUE loads all bits from the captured data and takes priority that cycle.
  - NSR[4] drives cluster SR; NSR[5] drives cluster KNN.
- Wired lines
  - id = OR of cluster id; unc = AND of cluster unclearn.
  - ID_l_OE = id & UNC_l_IN; UNC_l_OE = ~unc.
  - Cluster oktolearn_in = UNC_l_IN.
- Daisy chain: cluster k dci = cluster k-1 dco; cluster 0 dci = DCI; DCO = last cluster dco.

## Timing
- After G_RESET_l rises: RDY=0 for RESET_CYCLES cycles, then 1 on the next cycle.
- Access latency:
  - DS rise → ISSUE in 3 cycles.
  - RDY falls at ISSUE.
  - RDY rises 1 cycle after cluster ready is seen.
- Host rule: the host waits ≥4 G_CLK after DS rise before sampling RDY.
- Each DS pulse produces exactly one cluster ds cycle. A DS held high for N cycles produces no repeats.
- DS falling during ISSUE or WAIT: the access completes, HOLD is entered, and the state exits on its next cycle.
- FORGET: cluster reset_l low for exactly 1 cycle. NSR and the sequencer are unaffected.
- CS_l rising mid-access: the access completes, and standby takes effect on the first IDLE cycle.
- G_RESET_l low mid-access: immediate abort. All outputs return to their reset values and the counter reloads.

## Structure
- Shared package `nm_pkg` holds:
  - Register codes NETWORK_STATUS=4'hD, FORGET=4'hF.
  - Sequencer state enum.
  - NSR bit indices (ID=3, UNC=2, SR=4, KNN=5).
- Sub-module `nm_clk_gate`: latch-based glitch-free clock gate with enable = ~standby_r.
- Clusters are instantiated with a generate loop over NUM_CLUSTERS. Aggregation uses reduction logic over per-cluster vectors.

## Test plan
- Reset: pulse G_RESET_l low with RESET_CYCLES=16 → RDY=0 for 16 cycles, then 1; DATA_OE=0 and NSR=0.
- NSR write/read: write 0x0030 to REG 0xD, then read REG 0xD with ID_l_IN=1, UNC_l_IN=1 → DATA_OUT=0x0030; cluster SR=1, KNN=1; DATA_OE=1 until DS falls.
- Long DS: one write with DS held high for 40 cycles → exactly one cluster ds cycle; RDY returns to 1 while DS is still high.
- FORGET: write to REG 0xF → cluster reset_l low for exactly 1 cycle; NSR unchanged.
- Standby: CS_l raised during WAIT with cluster ready delayed 10 cycles → access completes; the gated clock stops only after IDLE; DS pulses are ignored during standby.
- NUM_CLUSTERS=5, cluster 2 holds ready low 20 cycles → RDY stays 0 until release; data is the AND of all 5 clusters; DCI propagates to DCO through all 5.
